// File: rtl/stage_fetch_queue.sv
// stage_fetch_queue: credit-based instruction fetch with an in-order queue.
// Redirects flush the queue and drop responses that are still in flight.
module stage_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_instr,
    input  logic        pcsrc,
    input  logic [31:0] pcbranch,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pcplus4
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_instr_mem [DEPTH];
    logic [31:0]   r_pc4_mem   [DEPTH];

    logic [CW:0]   w_credit_sum;
    logic          w_credit;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;
    logic [CW-1:0] w_resp_dec;

    // In-flight requests hold a credit, so the queue cannot overflow
    assign w_credit_sum   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_credit       = (w_credit_sum < (CW+1)'(DEPTH));
    assign imem_req_valid = w_credit && !pcsrc && reset;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push     = imem_resp_valid && (r_drop == '0) && !pcsrc;
    assign w_pop      = instr_valid && !stall && !pcsrc;
    assign w_target   = {pcbranch[31:2], 2'b00};
    assign w_resp_dec = CW'(imem_resp_valid);

    assign instr_valid = (r_count != '0);
    assign instr       = r_instr_mem[r_rptr];
    assign pcplus4     = r_pc4_mem[r_rptr];

    // Fetch/response PCs, occupancy, credits and drop bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_req_fire) - w_resp_dec;
            if (pcsrc) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_count    <= '0;
                r_drop     <= r_outst - w_resp_dec;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                    r_wptr    <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Queue storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wptr] <= imem_resp_instr;
            r_pc4_mem[r_wptr]   <= r_resp_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_stage_fetch_queue.sv
// tb_stage_fetch_queue: directed scenarios with a scoreboard on popped instructions.
// Memory model returns addr-derived words after a selectable latency.
module tb_stage_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;
    logic        pcsrc;
    logic [31:0] pcbranch;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pcplus4;

    int tests = 0;
    int fails = 0;
    int lat   = 1;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    logic        pv [4];
    logic [31:0] pa [4];

    always #5 clk = ~clk;

    stage_fetch_queue #(
        .DEPTH(4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_instr(imem_resp_instr),
        .pcsrc(pcsrc),
        .pcbranch(pcbranch),
        .stall(stall),
        .instr_valid(instr_valid),
        .instr(instr),
        .pcplus4(pcplus4)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_resp_valid = pv[lat-1];
    assign imem_resp_instr = memword(pa[lat-1]);

    // In-order memory with a fixed-latency delay line
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 32'h0;
            end
        end else begin
            for (int i = 3; i > 0; i--) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            pv[0] <= imem_req_valid && imem_req_ready;
            pa[0] <= imem_req_addr;
        end
    end

    // Monitor: every instruction decode takes is checked against the scoreboard
    always @(negedge clk) begin
        if (reset && instr_valid && !stall && !pcsrc && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (instr !== e.ins || pcplus4 !== e.pc4) begin
                fails++;
                $display("FAIL pop: got instr=%h pcplus4=%h expected instr=%h pcplus4=%h",
                         instr, pcplus4, e.ins, e.pc4);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input logic [31:0] a);
        exp_t e;
        e.ins = memword(a);
        e.pc4 = a + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic st, input int l);
        reset  = 1'b0;
        pcsrc  = 1'b0;
        stall  = st;
        lat    = l;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        pcsrc          = 1'b0;
        pcbranch       = 32'h0;
        stall          = 1'b0;
        #1;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);

        // Streaming, 1-cycle latency, no stall
        for (int a = 0; a < 24; a += 4) expect_at(32'(a));
        do_reset(1'b0, 1);
        check("a_req_valid0", 32'(imem_req_valid), 32'd1);
        check("a_req_addr0", imem_req_addr, 32'h0);
        tick();
        check("a_req_addr1", imem_req_addr, 32'h4);
        check("a_iv1", 32'(instr_valid), 32'd0);
        tick();
        check("a_iv2", 32'(instr_valid), 32'd1);
        check("a_pc4_2", pcplus4, 32'h4);
        check("a_req_addr2", imem_req_addr, 32'h8);
        wait_drain("a_drain");

        // Stall from reset fills the queue, then drains one per cycle
        for (int a = 0; a < 24; a += 4) expect_at(32'(a));
        do_reset(1'b1, 1);
        repeat (5) tick();
        check("b_req_valid_full", 32'(imem_req_valid), 32'd0);
        check("b_iv_full", 32'(instr_valid), 32'd1);
        check("b_head_pc4", pcplus4, 32'h4);
        repeat (2) tick();
        check("b_req_valid_hold", 32'(imem_req_valid), 32'd0);
        stall = 1'b0;
        tick();
        check("b_req_resume", 32'(imem_req_valid), 32'd1);
        check("b_req_addr", imem_req_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_iv_stream", 32'(instr_valid), 32'd1);
        end
        wait_drain("b_drain");

        // Redirect with two requests in flight (3-cycle latency)
        expect_at(32'h100);
        expect_at(32'h104);
        expect_at(32'h108);
        do_reset(1'b0, 3);
        tick();
        tick();
        pcsrc    = 1'b1;
        pcbranch = 32'h100;
        #1;
        check("c_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        pcsrc = 1'b0;
        #1;
        check("c_req_valid", 32'(imem_req_valid), 32'd1);
        check("c_req_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("c_iv_dropping", 32'(instr_valid), 32'd0);
        end
        tick();
        check("c_iv_first", 32'(instr_valid), 32'd1);
        check("c_pc4_first", pcplus4, 32'h104);
        wait_drain("c_drain");

        // Redirect while full and stalled
        expect_at(32'h40);
        expect_at(32'h44);
        expect_at(32'h48);
        do_reset(1'b1, 1);
        repeat (6) tick();
        check("d_iv_full", 32'(instr_valid), 32'd1);
        pcsrc    = 1'b1;
        pcbranch = 32'h40;
        #1;
        check("d_req_blocked", 32'(imem_req_valid), 32'd0);
        tick();
        pcsrc = 1'b0;
        stall = 1'b0;
        #1;
        check("d_iv_flushed", 32'(instr_valid), 32'd0);
        check("d_req_valid", 32'(imem_req_valid), 32'd1);
        check("d_req_addr", imem_req_addr, 32'h40);
        wait_drain("d_drain");

        // Back-to-back redirects; last target is misaligned
        expect_at(32'h0);
        expect_at(32'h100);
        expect_at(32'h104);
        do_reset(1'b0, 1);
        repeat (3) tick();
        pcsrc    = 1'b1;
        pcbranch = 32'h200;
        #1;
        check("e_req_blocked1", 32'(imem_req_valid), 32'd0);
        tick();
        pcbranch = 32'h103;
        #1;
        check("e_req_blocked2", 32'(imem_req_valid), 32'd0);
        tick();
        pcsrc = 1'b0;
        #1;
        check("e_req_valid", 32'(imem_req_valid), 32'd1);
        check("e_req_addr", imem_req_addr, 32'h100);
        check("e_iv_flushed", 32'(instr_valid), 32'd0);
        wait_drain("e_drain");

        // Asynchronous reset mid-stream, between edges
        expect_at(32'h0);
        expect_at(32'h4);
        do_reset(1'b0, 1);
        repeat (4) tick();
        check("f_pre_iv", 32'(instr_valid), 32'd1);
        check("f_pre_drained", 32'(exp_q.size()), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("f_async_iv", 32'(instr_valid), 32'd0);
        check("f_async_req", 32'(imem_req_valid), 32'd0);
        check("f_async_addr", imem_req_addr, 32'h0);
        expect_at(32'h0);
        expect_at(32'h4);
        expect_at(32'h8);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("f_restart_req", 32'(imem_req_valid), 32'd1);
        check("f_restart_addr", imem_req_addr, 32'h0);
        wait_drain("f_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_fetch_queue.md
STAGE_FETCH_QUEUE -- requirements
Module: stage_fetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of instruction-queue entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, and is the asynchronous reset, asserted when it is 0.
REQ-006 Port imem_req_valid SHALL be an output, 1 bit wide, and is the fetch request strobe.
REQ-007 Port imem_req_addr SHALL be an output, 32 bits wide, and is the fetch address.
REQ-008 Port imem_req_ready SHALL be an input, 1 bit wide; the memory accepts the request when both imem_req_valid and imem_req_ready are 1.
REQ-009 Port imem_resp_valid SHALL be an input, 1 bit wide; it is the response strobe, and responses arrive in order with latency of at least 1 cycle.
REQ-010 Port imem_resp_instr SHALL be an input, 32 bits wide, and is the response instruction word.
REQ-011 Port pcsrc SHALL be an input, 1 bit wide, and is the redirect (taken branch) strobe.
REQ-012 Port pcbranch SHALL be an input, 32 bits wide, and is the redirect target.
REQ-013 Port stall SHALL be an input, 1 bit wide; a value of 1 means decode will not take an instruction this cycle.
REQ-014 Port instr_valid SHALL be an output, 1 bit wide, and is 1 when the queue head is valid.
REQ-015 Port instr SHALL be an output, 32 bits wide, and is the queue-head instruction.
REQ-016 Port pcplus4 SHALL be an output, 32 bits wide, and is the address of the queue-head instruction plus 4.

Function
REQ-017 Internal fetch_pc SHALL drive imem_req_addr and SHALL advance by 4 (modulo 2^32) on each accepted request.
REQ-018 Credit rule: imem_req_valid SHALL equal (count + outstanding < DEPTH) AND NOT pcsrc AND reset deasserted. count is the number of queue entries; outstanding is the number of accepted requests whose responses have not yet returned.
REQ-019 As a result of REQ-018, the queue SHALL never overflow, including when a push and a pop occur in the same cycle while the queue is full.
REQ-020 Responses SHALL be tagged using internal resp_pc. On each kept response, {imem_resp_instr, resp_pc+4} SHALL be pushed at the tail, and resp_pc SHALL then advance by 4.
REQ-021 Pop: when instr_valid=1 and stall=0, the head SHALL be removed at the clock edge.
REQ-022 When push and pop occur in the same cycle, count SHALL be unchanged.
REQ-023 instr_valid SHALL equal (count != 0).
REQ-024 instr and pcplus4 SHALL be driven combinationally from the head entry.
REQ-025 Latency: a response accepted at edge N with the queue empty SHALL make instr_valid=1 in the cycle following edge N.
REQ-026 Redirect: when pcsrc=1 at an edge, the following SHALL happen at that edge:
  - fetch_pc and resp_pc <= {pcbranch[31:2], 2'b00};
  - count <= 0;
  - drop <= outstanding, excluding any response arriving that cycle.
REQ-027 In a redirect cycle, any pop SHALL be ignored and any response SHALL be discarded.
REQ-028 While drop > 0, each arriving response SHALL be discarded and SHALL decrement drop; it SHALL not push and SHALL not advance resp_pc.
REQ-029 Discarded responses SHALL still decrement outstanding.
REQ-030 A redirect SHALL take priority over push, pop and request.
REQ-031 Back-to-back redirects SHALL each retarget; only the last target SHALL be fetched.
REQ-032 Pointers SHALL be log2(DEPTH) bits wide and wrap naturally.
REQ-033 count, outstanding and drop SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-034 While reset=0, the following SHALL hold asynchronously:
  - fetch_pc=resp_pc=RESET_PC;
  - count=outstanding=drop=0;
  - instr_valid=0 and imem_req_valid=0;
  - imem_req_addr=RESET_PC.
REQ-035 Queue data SHALL not require reset; instr and pcplus4 are don't-care while instr_valid=0.
REQ-036 On the first edge after reset=1, imem_req_valid SHALL be 1 with imem_req_addr=RESET_PC.

Verification
REQ-037 Bench: DEPTH=4, RESET_PC=0, ready=1, 1-cycle response latency, stall=0 -> requests go out at 0x0,0x4,0x8,... every cycle, and pcplus4 follows the sequence 0x4,0x8,0xC.
REQ-038 Bench: stall=1 held from reset -> after 4 accepted requests, imem_req_valid=0 and count=4. Release stall -> one pop per cycle, and requests resume at 0x10.
REQ-039 Bench: 2 outstanding requests, pcsrc=1 with pcbranch=0x100 -> the next request address is 0x100. The next 2 responses are dropped, and the first instr_valid carries pcplus4=0x104.
REQ-040 Bench: queue full, stall=1, pcsrc=1 with pcbranch=0x40 -> instr_valid=0 next cycle, and the next request address is 0x40.
REQ-041 Bench: pcbranch=0x103 -> the fetch address is 0x100.
REQ-042 Bench: reset driven to 0 mid-stream between clock edges -> instr_valid=0 and imem_req_valid=0 immediately. After release, fetching restarts at 0x0, and stale in-flight responses are not expected from the memory model.
